xcore_if_bpu: RTL

Branch prediction stage directly downstream of the IF mini-decoder. It consumes the mini-decoder's instruction-class flags and offsets plus the fetch PC, and produces a registered next-PC prediction for the PC generator. Conditional branches are predicted with a PC-indexed table of 2-bit saturating counters. The execute stage trains the table through an update port.

---
 rtl/xcore_if_bpu_pkg.sv | 18 +
 rtl/xcore_if_bht.sv | 32 +++
 rtl/xcore_if_bpu.sv | 96 +++++++++
 3 files changed

// File: rtl/xcore_if_bpu_pkg.sv
// Shared widths, counter encoding and saturating-counter helper for the IF
// branch prediction unit.
package xcore_if_bpu_pkg;

  localparam int XLEN = 32;
  localparam int CTR_W = 2;
  localparam logic [CTR_W-1:0] BHT_RST_VAL = 2'b01;
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  function automatic logic [CTR_W-1:0] ctr_sat_next(input logic [CTR_W-1:0] ctr,
                                                     input logic taken);
    if (taken)
      return (ctr == '1) ? ctr : ctr + 1'b1;
    else
      return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/xcore_if_bht.sv
// Branch history table: 2-bit saturating counters, one combinational read
// port and one synchronous update port.
module xcore_if_bht
  import xcore_if_bpu_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int BHT_IDX_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [BHT_IDX_W-1:0] i_rd_idx,
  output logic [CTR_W-1:0]     o_rd_ctr,
  input  logic                 i_upd_vld,
  input  logic [BHT_IDX_W-1:0] i_upd_idx,
  input  logic                 i_upd_taken
);

  logic [CTR_W-1:0] ctr_q [BHT_DEPTH];

  // Read returns the pre-update value when read and update hit the same entry.
  assign o_rd_ctr = ctr_q[i_rd_idx];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        ctr_q[i] <= BHT_RST_VAL;
    end else if (i_upd_vld) begin
      ctr_q[i_upd_idx] <= ctr_sat_next(ctr_q[i_upd_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/xcore_if_bpu.sv
// IF-stage branch predictor: computes next PC from mini-decoder flags and the
// BHT, and registers it for the PC generator with one cycle of latency.
module xcore_if_bpu
  import xcore_if_bpu_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int BHT_IDX_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_mdec_instr_vld,
  input  logic            i_mdec_b,
  input  logic            i_mdec_jal,
  input  logic            i_mdec_jalr,
  input  logic [XLEN-1:0] i_mdec_b_ofs,
  input  logic [XLEN-1:0] i_mdec_jal_ofs,
  input  logic            i_pc_instr_vld,
  input  logic            i_if_stall,
  input  logic            i_flush,
  input  logic            i_ex_upd_vld,
  input  logic [XLEN-1:0] i_ex_upd_pc,
  input  logic            i_ex_upd_taken,
  output logic            o_bpu_vld,
  output logic            o_bpu_taken,
  output logic [XLEN-1:0] o_bpu_npc,
  output logic            o_bpu_jalr,
  output logic [XLEN-1:0] o_bpu_pc
);

  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [CTR_W-1:0]     rd_ctr;
  logic                 pred_taken;
  logic                 pred_jalr;
  logic [XLEN-1:0]      pred_npc;

  // Word-aligned index: drop the two byte-offset bits, keep the low BHT_IDX_W.
  assign rd_idx  = BHT_IDX_W'(i_pc >> 2);
  assign upd_idx = BHT_IDX_W'(i_ex_upd_pc >> 2);

  xcore_if_bht #(
    .BHT_DEPTH (BHT_DEPTH),
    .BHT_IDX_W (BHT_IDX_W)
  ) u_bht (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_idx    (rd_idx),
    .o_rd_ctr    (rd_ctr),
    .i_upd_vld   (i_ex_upd_vld),
    .i_upd_idx   (upd_idx),
    .i_upd_taken (i_ex_upd_taken)
  );

  always_comb begin
    pred_taken = 1'b0;
    pred_jalr  = 1'b0;
    pred_npc   = i_pc + INSTR_BYTES;
    if (i_mdec_instr_vld) begin
      if (i_mdec_jal) begin
        pred_taken = 1'b1;
        pred_npc   = i_pc + i_mdec_jal_ofs;
      end else if (i_mdec_b) begin
        pred_taken = rd_ctr[CTR_W-1];
        if (rd_ctr[CTR_W-1])
          pred_npc = i_pc + i_mdec_b_ofs;
      end else if (i_mdec_jalr) begin
        pred_jalr = 1'b1;
      end
    end
  end

  // Flush wins over stall; npc/pc are don't-care after a flush so they just load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bpu_vld   <= 1'b0;
      o_bpu_taken <= 1'b0;
      o_bpu_jalr  <= 1'b0;
      o_bpu_npc   <= '0;
      o_bpu_pc    <= '0;
    end else if (i_flush) begin
      o_bpu_vld   <= 1'b0;
      o_bpu_taken <= 1'b0;
      o_bpu_jalr  <= 1'b0;
      o_bpu_npc   <= pred_npc;
      o_bpu_pc    <= i_pc;
    end else if (!i_if_stall) begin
      o_bpu_vld   <= i_pc_instr_vld;
      o_bpu_taken <= pred_taken;
      o_bpu_jalr  <= pred_jalr;
      o_bpu_npc   <= pred_npc;
      o_bpu_pc    <= i_pc;
    end
  end

endmodule
